// File: rtl/soc_dac_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_dac_clk_pkg
//  Description : Shared constants, counter-width helper and divider counter
//                type for the DAC clock-control block.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_dac_clk_pkg;

    // Default configuration of the DAC clock path
    localparam int C_DEF_DAC_CLK_FACTOR = 8;
    localparam int C_DEF_DOUT_WIDTH     = 8;
    localparam int C_DEF_LOCK_CYCLES    = 16;

    // Counter width that never collapses to zero bits
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int HALF = C_DEF_DAC_CLK_FACTOR / 2;
    localparam int LAST = C_DEF_DAC_CLK_FACTOR - 1;

    typedef logic [cnt_w(C_DEF_DAC_CLK_FACTOR)-1:0] div_cnt_t;

endpackage : soc_dac_clk_pkg
`default_nettype wire

// File: rtl/soc_dac_clk_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : soc_dac_clk_ctrl_if
//  Description : Enable / lock / DAC clock and sample bundle between the
//                clock controller (master) and its consumer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface soc_dac_clk_ctrl_if #(
    parameter int DOUT_WIDTH = 8
);
    logic                  en;
    logic                  locked;
    logic                  dac_clk;
    logic [DOUT_WIDTH-1:0] dout;

    modport master (
        input  en,
        output locked,
        output dac_clk,
        output dout
    );

    modport slave (
        output en,
        input  locked,
        input  dac_clk,
        input  dout
    );
endinterface : soc_dac_clk_ctrl_if
`default_nettype wire

// File: rtl/soc_dac_clk_ctrl_lock_timer.sv
`default_nettype none
// ============================================================================
//  Module      : soc_dac_clk_ctrl_lock_timer
//  Description : Qualifies the reference clock LOCK_CYCLES edges after reset
//                release; locked is sticky until the next reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_dac_clk_ctrl_lock_timer
    import soc_dac_clk_pkg::*;
#(
    parameter int LOCK_CYCLES = 16
) (
    input  wire  ref_clk,
    input  wire  rst_n,
    output logic locked
);

    localparam int                 CNT_W  = cnt_w(LOCK_CYCLES);
    localparam logic [CNT_W-1:0]   C_TERM = CNT_W'(LOCK_CYCLES - 1);

    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_locked;

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (!r_locked) begin
            r_lock_cnt <= r_lock_cnt + CNT_W'(1);
            if (r_lock_cnt == C_TERM) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign locked = r_locked;

endmodule : soc_dac_clk_ctrl_lock_timer
`default_nettype wire

// File: rtl/soc_dac_clk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : soc_dac_clk_ctrl
//  Description : Portable DAC clock front end: lock timer, gated 50% duty
//                divider and a ramp sample generator aligned to dac_clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_dac_clk_ctrl
    import soc_dac_clk_pkg::*;
#(
    parameter int DAC_CLK_FACTOR = C_DEF_DAC_CLK_FACTOR,
    parameter int DOUT_WIDTH     = C_DEF_DOUT_WIDTH,
    parameter int LOCK_CYCLES    = C_DEF_LOCK_CYCLES
) (
    input  wire                    ref_clk,
    input  wire                    rst_n,
    soc_dac_clk_ctrl_if.master     dac
);

    localparam int               DIV_W     = cnt_w(DAC_CLK_FACTOR);
    localparam logic [DIV_W-1:0] C_HALF_M1 = DIV_W'(DAC_CLK_FACTOR / 2 - 1);
    localparam logic [DIV_W-1:0] C_LAST    = DIV_W'(DAC_CLK_FACTOR - 1);

    logic                  w_locked;
    logic                  w_run;
    logic [DIV_W-1:0]      r_div_cnt;
    logic                  r_dac_clk;
    logic [DOUT_WIDTH-1:0] r_dout;

    soc_dac_clk_ctrl_lock_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_timer (
        .ref_clk (ref_clk),
        .rst_n   (rst_n),
        .locked  (w_locked)
    );

    assign w_run = w_locked & dac.en;

    // Everything freezes while not running, so re-enable resumes mid-period
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_dac_clk <= 1'b0;
            r_dout    <= '0;
        end else if (w_run) begin
            if (r_div_cnt == C_LAST) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            // Sample advances on the rising dac_clk edge; DAC samples on the fall
            if (r_div_cnt == C_HALF_M1) begin
                r_dac_clk <= 1'b1;
                r_dout    <= r_dout + DOUT_WIDTH'(1);
            end else if (r_div_cnt == C_LAST) begin
                r_dac_clk <= 1'b0;
            end
        end
    end

    assign dac.locked  = w_locked;
    assign dac.dac_clk = r_dac_clk;
    assign dac.dout    = r_dout;

endmodule : soc_dac_clk_ctrl
`default_nettype wire

// File: tb/tb_soc_dac_clk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_dac_clk_ctrl
//  Description : Self-checking bench for soc_dac_clk_ctrl (default config and
//                a DAC_CLK_FACTOR=2 / DOUT_WIDTH=4 / LOCK_CYCLES=3 config).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_dac_clk_ctrl;

    localparam int L0 = 16;
    localparam int F0 = 8;
    localparam int H0 = 4;
    localparam int L1 = 3;
    localparam int F1 = 2;
    localparam int H1 = 1;

    logic ref_clk = 1'b0;
    logic rst_n   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges since reset release and run-edge counts per DUT
    int since_rst = 0;
    int n0        = 0;
    int n1        = 0;

    soc_dac_clk_ctrl_if #(.DOUT_WIDTH(8)) bus0 ();
    soc_dac_clk_ctrl_if #(.DOUT_WIDTH(4)) bus1 ();

    soc_dac_clk_ctrl #(
        .DAC_CLK_FACTOR (F0),
        .DOUT_WIDTH     (8),
        .LOCK_CYCLES    (L0)
    ) u_dut0 (
        .ref_clk (ref_clk),
        .rst_n   (rst_n),
        .dac     (bus0.master)
    );

    soc_dac_clk_ctrl #(
        .DAC_CLK_FACTOR (F1),
        .DOUT_WIDTH     (4),
        .LOCK_CYCLES    (L1)
    ) u_dut1 (
        .ref_clk (ref_clk),
        .rst_n   (rst_n),
        .dac     (bus1.master)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            since_rst <= 0;
            n0        <= 0;
            n1        <= 0;
        end else begin
            since_rst <= since_rst + 1;
            if (since_rst >= L0 && bus0.en === 1'b1) n0 <= n0 + 1;
            if (since_rst >= L1 && bus1.en === 1'b1) n1 <= n1 + 1;
        end
    end

    // After n run edges: dac_clk high in the second half of the period,
    // dout counts completed rises (rise k happens at run edge HALF + k*F)
    always @(negedge ref_clk) begin
        check("locked0",  {31'b0, bus0.locked},  {31'b0, since_rst >= L0});
        check("dac_clk0", {31'b0, bus0.dac_clk}, {31'b0, (n0 % F0) >= H0});
        check("dout0",    {24'b0, bus0.dout},    32'(((n0 + H0) / F0) % 256));
        check("locked1",  {31'b0, bus1.locked},  {31'b0, since_rst >= L1});
        check("dac_clk1", {31'b0, bus1.dac_clk}, {31'b0, (n1 % F1) >= H1});
        check("dout1",    {28'b0, bus1.dout},    32'(((n1 + H1) / F1) % 16));
    end

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge ref_clk);
    endtask

    task automatic rand_en(input int cycles, input bit drive0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge ref_clk);
            #1;
            if (drive0) bus0.en = 1'($urandom_range(0, 1));
            bus1.en = 1'($urandom_range(0, 3) != 0);
        end
    endtask

    logic [7:0] hold_dout;
    logic       hold_clk;
    int         cnt;
    bit         done;

    initial begin
        bus0.en = 1'b0;
        bus1.en = 1'b0;
        wait_neg(2);
        check("rst_locked",  {31'b0, bus0.locked},  32'd0);
        check("rst_dac_clk", {31'b0, bus0.dac_clk}, 32'd0);
        check("rst_dout",    {24'b0, bus0.dout},    32'd0);

        // Lock timing with en held high
        #2 rst_n = 1'b1;
        bus0.en = 1'b1;
        bus1.en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge ref_clk);
            check("lock_seq", {31'b0, bus0.locked}, {31'b0, k >= 16});
            check("prelock_clk", {31'b0, bus0.dac_clk}, 32'd0);
        end

        // First rise 4 edges after lock, then 4 high / 4 low
        wait_neg(3);
        check("pre_rise_clk", {31'b0, bus0.dac_clk}, 32'd0);
        wait_neg(1);
        check("first_rise_clk",  {31'b0, bus0.dac_clk}, 32'd1);
        check("first_rise_dout", {24'b0, bus0.dout},    32'd1);
        wait_neg(4);
        check("first_fall_clk",  {31'b0, bus0.dac_clk}, 32'd0);
        check("first_fall_dout", {24'b0, bus0.dout},    32'd1);
        wait_neg(4);
        check("second_rise_dout", {24'b0, bus0.dout},   32'd2);

        // Gate while div_cnt == 2
        cnt = 0;
        while ((n0 % F0) != 2 && cnt < 16) begin
            wait_neg(1);
            cnt++;
        end
        hold_dout = bus0.dout;
        hold_clk  = bus0.dac_clk;
        #1 bus0.en = 1'b0;
        wait_neg(5);
        check("gate_hold_dout", {24'b0, bus0.dout},    {24'b0, hold_dout});
        check("gate_hold_clk",  {31'b0, bus0.dac_clk}, {31'b0, hold_clk});
        #1 bus0.en = 1'b1;
        wait_neg(1);
        check("resume_1_clk", {31'b0, bus0.dac_clk}, 32'd0);
        wait_neg(1);
        check("resume_2_clk",  {31'b0, bus0.dac_clk}, 32'd1);
        check("resume_2_dout", {24'b0, bus0.dout},    32'(hold_dout + 8'd1));

        // Ramp wrap 255 -> 0
        done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            wait_neg(1);
            if (bus0.dout == 8'd255) done = 1;
        end
        check("reach_255", {31'b0, done}, 32'd1);
        wait_neg(8);
        check("wrap_dout", {24'b0, bus0.dout},    32'd0);
        check("wrap_clk",  {31'b0, bus0.dac_clk}, 32'd1);

        rand_en(600, 1'b1);

        // Asynchronous reset while dac_clk high and dout == 37
        #1 bus0.en = 1'b1;
        done = 0;
        for (int i = 0; i < 5000 && !done; i++) begin
            wait_neg(1);
            if (bus0.dout == 8'd37 && bus0.dac_clk) done = 1;
        end
        check("reach_37", {31'b0, done}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_locked",  {31'b0, bus0.locked},  32'd0);
        check("async_dac_clk", {31'b0, bus0.dac_clk}, 32'd0);
        check("async_dout",    {24'b0, bus0.dout},    32'd0);
        check("async_dout1",   {28'b0, bus1.dout},    32'd0);
        wait_neg(1);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge ref_clk);
            check("relock_seq", {31'b0, bus0.locked}, {31'b0, k >= 16});
            #1 bus0.en = 1'b1 ^ 1'($urandom_range(0, 1));
        end

        rand_en(400, 1'b1);
        #1 bus0.en = 1'b1;
        wait_neg(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_soc_dac_clk_ctrl
`default_nettype wire
